// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared event codes and channel FSM state encoding
package key_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_channel_fsm.sv
// rtl/key_channel_fsm.sv - one key channel: press/long/repeat FSM, hold counter, one-deep slot
module key_channel_fsm
    import key_evt_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rise,
    input  logic       fall,
    input  logic       drain,
    output logic       pend,
    output logic [1:0] pend_type,
    output logic       drop
);

    localparam logic [31:0] LONG_TERM   = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REPEAT_TERM = 32'(REPEAT_CYCLES - 1);

    key_state_t  state;
    logic [31:0] cnt;
    logic        gen;
    logic [1:0]  gen_type;

    // A falling edge wins over a LONG/REPEAT that is due in the same cycle.
    always_comb begin
        gen      = 1'b0;
        gen_type = EVT_PRESS;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    gen      = 1'b1;
                    gen_type = EVT_PRESS;
                end
            end
            ST_DOWN: begin
                if (fall) begin
                    gen      = 1'b1;
                    gen_type = EVT_RELEASE;
                end else if (cnt == LONG_TERM) begin
                    gen      = 1'b1;
                    gen_type = EVT_LONG;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    gen      = 1'b1;
                    gen_type = EVT_RELEASE;
                end else if (REPEAT_EN && cnt == REPEAT_TERM) begin
                    gen      = 1'b1;
                    gen_type = EVT_REPEAT;
                end
            end
            default: ;
        endcase
    end

    assign drop = gen && pend && !drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 32'd0;
            pend      <= 1'b0;
            pend_type <= EVT_PRESS;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_DOWN;
                        cnt   <= 32'd0;
                    end
                end
                ST_DOWN: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= 32'd0;
                    end else if (cnt == LONG_TERM) begin
                        state <= ST_HELD;
                        cnt   <= 32'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        state <= ST_IDLE;
                        cnt   <= 32'd0;
                    end else if (!REPEAT_EN || cnt == REPEAT_TERM) begin
                        cnt <= 32'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 32'd0;
                end
            endcase

            // The slot may be refilled in the same cycle it drains to the output.
            if (gen && (!pend || drain)) begin
                pend      <= 1'b1;
                pend_type <= gen_type;
            end else if (drain) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - key edge capture, per-channel event FSMs, priority arbiter, event port
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int unsigned    NCH           = 5,
    parameter int unsigned    LONG_CYCLES   = 50_000_000,
    parameter int unsigned    REPEAT_CYCLES = 10_000_000,
    parameter logic [NCH-1:0] REPEAT_MASK   = 5'b01111
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] key_stable,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [2:0]     evt_chan,
    output logic [1:0]     evt_type,
    output logic           overflow
);

    logic [NCH-1:0] key_q;
    logic [NCH-1:0] key_qq;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] drain;
    logic [NCH-1:0] drop;
    logic [1:0]     ptype [NCH];

    logic           load_en;
    logic           any;
    logic [2:0]     sel;
    logic [1:0]     sel_type;

    assign rise = key_q & ~key_qq;
    assign fall = ~key_q & key_qq;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        key_channel_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .drain     (drain[i]),
            .pend      (pend[i]),
            .pend_type (ptype[i]),
            .drop      (drop[i])
        );
    end

    // Output register refills whenever it is empty or being accepted, so back-to-back events have no bubble.
    assign load_en = !evt_valid || evt_ready;

    always_comb begin
        any      = 1'b0;
        sel      = 3'd0;
        sel_type = EVT_PRESS;
        drain    = '0;
        for (int i = 0; i < NCH; i++) begin
            drain[i] = load_en && pend[i] && !any;
            if (pend[i] && !any) begin
                sel      = 3'(i);
                sel_type = ptype[i];
            end
            any = any | pend[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            key_qq    <= '0;
            evt_valid <= 1'b0;
            evt_chan  <= 3'd0;
            evt_type  <= EVT_PRESS;
            overflow  <= 1'b0;
        end else begin
            key_q  <= key_stable;
            key_qq <= key_q;
            if (load_en) begin
                evt_valid <= any;
                if (any) begin
                    evt_chan <= sel;
                    evt_type <= sel_type;
                end
            end
            overflow <= overflow | (|drop);
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - scoreboard bench for key_event_decoder
module tb_key_event_decoder;

    localparam int T_PRESS   = 0;
    localparam int T_RELEASE = 1;
    localparam int T_LONG    = 2;
    localparam int T_REPEAT  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key_stable = 5'd0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [2:0] evt_chan;
    logic [1:0] evt_type;
    logic       overflow;

    key_event_decoder #(
        .NCH           (5),
        .LONG_CYCLES   (1000),
        .REPEAT_CYCLES (1000),
        .REPEAT_MASK   (5'b01111)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_stable (key_stable),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_chan   (evt_chan),
        .evt_type   (evt_type),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int chan;
        int typ;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int t, input int a);
        exp_t e;
        e.chan = c;
        e.typ  = t;
        e.at   = a;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain_q(input int max);
        int k;
        k = 0;
        while (sbq.size() > 0 && k < max) begin
            step(1);
            k++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d events outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: every accepted event is compared against the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && evt_valid && evt_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got chan %0d type %0d at cycle %0d, expected none",
                         evt_chan, evt_type, cyc);
            end else begin
                e = sbq.pop_front();
                chk("evt_chan", int'(evt_chan), e.chan);
                chk("evt_type", int'(evt_type), e.typ);
                if (e.at >= 0) chk("evt_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int p;
        int q;

        step(3);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_chan", int'(evt_chan), 0);
        chk("rst_type", int'(evt_type), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        step(3);

        // Short press on ch1.
        evt_ready = 1'b1;
        p = cyc;
        key_stable[1] = 1'b1;
        push(1, T_PRESS, p + 3);
        step(100);
        key_stable[1] = 1'b0;
        push(1, T_RELEASE, p + 103);
        drain_q(50);
        chk("short_overflow", int'(overflow), 0);

        // Long hold with repeats on ch0.
        step(5);
        p = cyc;
        key_stable[0] = 1'b1;
        push(0, T_PRESS, p + 3);
        push(0, T_LONG, p + 1003);
        push(0, T_REPEAT, p + 2003);
        push(0, T_REPEAT, p + 3003);
        step(3500);
        key_stable[0] = 1'b0;
        push(0, T_RELEASE, p + 3503);
        drain_q(50);

        // Power channel does not repeat.
        step(5);
        p = cyc;
        key_stable[4] = 1'b1;
        push(4, T_PRESS, p + 3);
        push(4, T_LONG, p + 1003);
        step(3500);
        key_stable[4] = 1'b0;
        push(4, T_RELEASE, p + 3503);
        drain_q(50);

        // Simultaneous presses under backpressure.
        step(5);
        evt_ready = 1'b0;
        key_stable[2] = 1'b1;
        key_stable[3] = 1'b1;
        step(3);
        for (int i = 0; i < 9; i++) begin
            chk("stall_valid", int'(evt_valid), 1);
            chk("stall_chan", int'(evt_chan), 2);
            chk("stall_type", int'(evt_type), T_PRESS);
            step(1);
        end
        q = cyc;
        evt_ready = 1'b1;
        push(2, T_PRESS, q);
        push(3, T_PRESS, q + 1);
        drain_q(20);
        key_stable[2] = 1'b0;
        key_stable[3] = 1'b0;
        q = cyc;
        push(2, T_RELEASE, q + 3);
        push(3, T_RELEASE, q + 4);
        drain_q(20);

        // Overflow: output holds PRESS, slot holds RELEASE, later events dropped.
        step(5);
        evt_ready = 1'b0;
        key_stable[0] = 1'b1;
        step(5);
        key_stable[0] = 1'b0;
        step(5);
        key_stable[0] = 1'b1;
        step(5);
        chk("ovf_valid", int'(evt_valid), 1);
        chk("ovf_chan", int'(evt_chan), 0);
        chk("ovf_type", int'(evt_type), T_PRESS);
        chk("ovf_set", int'(overflow), 1);
        key_stable[0] = 1'b0;
        step(5);
        chk("ovf_hold_type", int'(evt_type), T_PRESS);
        q = cyc;
        evt_ready = 1'b1;
        push(0, T_PRESS, q);
        push(0, T_RELEASE, q + 1);
        drain_q(20);
        step(5);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset while a LONG is presented and unaccepted.
        p = cyc;
        key_stable[0] = 1'b1;
        push(0, T_PRESS, p + 3);
        step(5);
        evt_ready = 1'b0;
        step(1100);
        chk("pre_rst_valid", int'(evt_valid), 1);
        chk("pre_rst_type", int'(evt_type), T_LONG);
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(evt_valid), 0);
        chk("async_type", int'(evt_type), 0);
        chk("async_chan", int'(evt_chan), 0);
        chk("async_overflow", int'(overflow), 0);
        step(1);
        rst_n = 1'b1;
        q = cyc;
        evt_ready = 1'b1;
        push(0, T_PRESS, q + 3);
        drain_q(20);
        step(10);
        key_stable[0] = 1'b0;
        q = cyc;
        push(0, T_RELEASE, q + 3);
        drain_q(20);
        step(20);
        chk("final_overflow", int'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
